data_mem_responder: RTL and testbench

- Data-memory responder on the far side of the control unit's MemRead/MemWrite strobes.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs the RV32I byte, half or word access into an internal word-organised RAM after a programmable latency.
- Returns load data, sign- or zero-extended per funct3, with a one-cycle response strobe; the multi-cycle datapath stalls on req_ready.

---
 rtl/data_mem_if.sv | 24 ++
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store request and response bundle between a multi-cycle datapath and its data memory.
// The master raises requests and stalls on req_ready; the slave returns a one-cycle resp_valid strobe.
interface data_mem_if;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, mem_read, mem_write, addr, wdata, funct3,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, wdata, funct3,
    output req_ready, resp_valid, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I byte/half/word data memory; response strobe LATENCY+1 cycles after accept, one request in flight.
// Backpressure: req_ready is low from accept until the cycle after the response strobe.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic        clk,
  input logic        rst_n,
  data_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only the byte-address bits that reach the RAM are kept; higher bits alias.
  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    f3;
  } req_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  req_t          req_q, req_n;
  logic [31:0]   rdata_q, rdata_n;
  logic          err_q, err_n;

  logic [31:0]   ram [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   cur_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   store_word;
  logic          is_load, is_store;
  logic          fmt_err, align_err, acc_err;
  logic          resp_err, ram_we;
  logic          unused_addr;

  assign unused_addr = ^bus.addr[31:AW+2];

  assign word_idx = req_q.addr[AW+1:2];
  assign lane     = req_q.addr[1:0];
  assign cur_word = ram[word_idx];

  // A set write strobe wins over a read: the store is carried out and the request is flagged.
  assign is_store = req_q.wr;
  assign is_load  = req_q.rd & ~req_q.wr;

  always_comb begin
    fmt_err = 1'b0;
    if (is_store)
      fmt_err = !(req_q.f3 == 3'b000 || req_q.f3 == 3'b001 || req_q.f3 == 3'b010);
    else if (is_load)
      fmt_err = (req_q.f3 == 3'b011 || req_q.f3 == 3'b110 || req_q.f3 == 3'b111);
  end

  always_comb begin
    align_err = 1'b0;
    case (req_q.f3[1:0])
      2'b01:   align_err = lane[0];
      2'b10:   align_err = (lane != 2'b00);
      default: align_err = 1'b0;
    endcase
  end

  assign acc_err  = fmt_err | align_err;
  assign resp_err = ((is_load | is_store) & acc_err) | (req_q.rd & req_q.wr);

  always_comb begin
    byte_sel = cur_word[7:0];
    case (lane)
      2'd0: byte_sel = cur_word[7:0];
      2'd1: byte_sel = cur_word[15:8];
      2'd2: byte_sel = cur_word[23:16];
      2'd3: byte_sel = cur_word[31:24];
      default: byte_sel = cur_word[7:0];
    endcase
  end

  assign half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (req_q.f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = 32'h0;
    endcase
  end

  // Read-modify-write merge so unaddressed bytes of the word are preserved.
  always_comb begin
    store_word = cur_word;
    case (req_q.f3[1:0])
      2'b00: begin
        case (lane)
          2'd0: store_word[7:0]   = req_q.wdata[7:0];
          2'd1: store_word[15:8]  = req_q.wdata[7:0];
          2'd2: store_word[23:16] = req_q.wdata[7:0];
          2'd3: store_word[31:24] = req_q.wdata[7:0];
          default: store_word = cur_word;
        endcase
      end
      2'b01: begin
        if (lane[1]) store_word[31:16] = req_q.wdata[15:0];
        else         store_word[15:0]  = req_q.wdata[15:0];
      end
      2'b10:   store_word = req_q.wdata;
      default: store_word = cur_word;
    endcase
  end

  // Commit on the edge that enters RESP; a reset before that edge leaves the RAM untouched.
  assign ram_we = (state == BUSY) && (cnt == '0) && is_store && !acc_err;

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[word_idx] <= store_word;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          req_n.rd    = bus.mem_read;
          req_n.wr    = bus.mem_write;
          req_n.addr  = bus.addr[AW+1:0];
          req_n.wdata = bus.wdata;
          req_n.f3    = bus.funct3;
          cnt_n       = CW'(LATENCY - 1);
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          rdata_n = (is_load && !acc_err) ? load_val : 32'h0;
          err_n   = resp_err;
          state_n = RESP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        rdata_n = 32'h0;
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      req_q   <= req_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  assign bus.req_ready  = (state == IDLE) && rst_n;
  assign bus.resp_valid = (state == RESP);
  assign bus.rdata      = (state == RESP) ? rdata_q : 32'h0;
  assign bus.err        = (state == RESP) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_mem_if bus();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response, and check timing plus strobe width.
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        output logic [31:0] rdv, output logic ev);
    logic seen;
    int   lat;
    rdv = 32'h0;
    ev  = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    bus.funct3    = f3;
    bus.req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_acc"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        lat  = i;
        rdv  = bus.rdata;
        ev   = bus.err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    @(negedge clk);
    chk({tag, "_strobe"}, {bus.resp_valid, bus.req_ready, bus.rdata[29:0]}, 32'h4000_0000);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] r;
    logic        e;
    do_req(tag, 1'b1, 1'b0, a, 32'h0, f3, r, e);
    chk({tag, "_rdata"}, r, exp_d);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f3, input logic exp_e);
    logic [31:0] r;
    logic        e;
    do_req(tag, 1'b0, 1'b1, a, d, f3, r, e);
    chk({tag, "_rdata"}, r, 32'h0);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          acc, resps, a1, a2, nresp;
    logic [31:0] last;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.funct3    = 3'b000;

    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp", {bus.resp_valid, bus.err, 30'h0}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.req_ready), 32'd1);

    // Word, byte and half accesses
    st("sw20", 32'h20, 32'h1234_5678, 3'b010, 1'b0);
    ld("lw20", 32'h20, 3'b010, 32'h1234_5678, 1'b0);
    st("sb21", 32'h21, 32'h0000_00A5, 3'b000, 1'b0);
    ld("lw20b", 32'h20, 3'b010, 32'h1234_A578, 1'b0);
    ld("lb21", 32'h21, 3'b000, 32'hFFFF_FFA5, 1'b0);
    ld("lbu21", 32'h21, 3'b100, 32'h0000_00A5, 1'b0);
    ld("lh22", 32'h22, 3'b001, 32'h0000_1234, 1'b0);
    ld("lh20", 32'h20, 3'b001, 32'hFFFF_A578, 1'b0);
    ld("lhu20", 32'h20, 3'b101, 32'h0000_A578, 1'b0);

    // Misaligned and illegal encodings
    ld("lw22", 32'h22, 3'b010, 32'h0, 1'b1);
    st("sh23", 32'h23, 32'h0000_FFFF, 3'b001, 1'b1);
    ld("lw20c", 32'h20, 3'b010, 32'h1234_A578, 1'b0);
    ld("ld011", 32'h20, 3'b011, 32'h0, 1'b1);
    st("sd011", 32'h20, 32'hFFFF_FFFF, 3'b011, 1'b1);
    ld("lw20d", 32'h20, 3'b010, 32'h1234_A578, 1'b0);

    // Address wrap, strobe conflict, no-op
    st("sw400", 32'h400, 32'hCAFE_F00D, 3'b010, 1'b0);
    ld("lw000", 32'h000, 3'b010, 32'hCAFE_F00D, 1'b0);
    do_req("both", 1'b1, 1'b1, 32'h30, 32'h55AA_55AA, 3'b010, r, e);
    chk("both_rdata", r, 32'h0);
    chk("both_err", 32'(e), 32'd1);
    ld("lw30", 32'h30, 3'b010, 32'h55AA_55AA, 1'b0);
    do_req("noop", 1'b0, 1'b0, 32'h30, 32'h0, 3'b010, r, e);
    chk("noop_rdata", r, 32'h0);
    chk("noop_err", 32'(e), 32'd0);
    st("sh32", 32'h32, 32'h0000_BEEF, 3'b001, 1'b0);
    ld("lw30b", 32'h30, 3'b010, 32'hBEEF_55AA, 1'b0);

    // Back-to-back with req_valid held high
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr      = 32'h40;
    bus.wdata     = 32'h0BAD_C0DE;
    bus.funct3    = 3'b010;
    bus.req_valid = 1'b1;
    acc = 0; resps = 0; a1 = -1; a2 = -1; last = 32'h0;
    for (int i = 0; i < 30; i++) begin
      if (bus.resp_valid) begin
        resps++;
        last = bus.rdata;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (acc == 0) a1 = i;
        else          a2 = i;
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc == 1) begin
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        bus.wdata     = 32'h0;
      end
      if (acc >= 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_acc", 32'(acc), 32'd2);
    chk("b2b_gap", 32'(a2 - a1), 32'(LAT + 2));
    chk("b2b_resps", 32'(resps), 32'd2);
    chk("b2b_ldata", last, 32'h0BAD_C0DE);

    // Reset during BUSY aborts a store
    st("sw10", 32'h10, 32'h1111_1111, 3'b010, 1'b0);
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr      = 32'h10;
    bus.wdata     = 32'hDEAD_BEEF;
    bus.funct3    = 3'b010;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_resp", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", 32'(bus.req_ready), 32'd1);
    nresp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("abort_noresp", 32'(nresp), 32'd0);
    ld("lw10", 32'h10, 3'b010, 32'h1111_1111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
